// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter, port 0 priority with bounded port 1 starvation
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic [3:0] hold_cnt;
    logic       holdFull;

    assign holdFull = (hold_cnt == HOLD_LIMIT);

    // Grants are masked while reset is asserted so no access reaches memory during reset.
    assign p1_gnt = rst_n & p1_req & (~p0_req | holdFull);
    assign p0_gnt = rst_n & p0_req & ~p1_gnt;
    assign stall  = p0_req & p1_gnt;

    assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign mem_write = (p0_gnt & p0_we)  | (p1_gnt & p1_we);
    assign mem_read  = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            if (p1_gnt || !p1_req) begin
                hold_cnt <= '0;
            end else if (p0_gnt && !holdFull) begin
                hold_cnt <= hold_cnt + 4'd1;
            end

            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters:
  - port 0: the MEM pipeline stage.
  - port 1: a loader/debug master.
- Grants one access per cycle and drives the memory address, data and strobes.
- Returns read data one cycle later, with a valid pulse, to the port that issued the read.
- Port 0 has priority. A hold counter bounds how long port 1 can be starved.
- Produces the pipeline stall when port 0 loses arbitration.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 4, maximum consecutive port-0 grants while port 1 is waiting (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered).
- p0_rdata  out  DW  port 0 read data (registered).
- p1_req  in  1  port 1 access request.
- p1_we  in  1  port 1 write / read.
- p1_addr  in  AW  port 1 address.
- p1_wdata  in  DW  port 1 write data.
- p1_gnt  out  1  port 1 granted this cycle.
- p1_rvalid  out  1  port 1 read data valid.
- p1_rdata  out  DW  port 1 read data.
- mem_addr  out  AW  to data memory address.
- mem_wdata  out  DW  to data memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  DW  memory read data, valid combinationally in the cycle mem_read is high.
- stall  out  1  p0_req & ~p0_gnt; freezes the pipeline.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - hold_cnt = 0.
  - p0_rvalid = p1_rvalid = 0.
  - p0_rdata = p1_rdata = 0.
  - Combinational outputs follow from the zeroed state.
- Grant rule (combinational, evaluated every cycle):
  - p1_gnt = p1_req & (~p0_req | hold_cnt == MAX_HOLD).
  - p0_gnt = p0_req & ~p1_gnt.
  - At most one grant per cycle. No grant when neither port requests.
- Hold counter update at posedge:
  - p0_gnt & p1_req: increment.
  - p1_gnt, or p1_req low: clear to 0.
  - Never exceeds MAX_HOLD.
- Memory side:
  - mem_addr/mem_wdata = the granted port's fields. They are driven from port 0 when no grant.
  - mem_write = gnt & we of the granted port.
  - mem_read = gnt & ~we of the granted port.
  - Both strobes are low when idle.
- Writes commit at the posedge ending the grant cycle. A write produces no rvalid.
- Read latency is 1 cycle. On a granted read, mem_rdata is registered into pN_rdata at that posedge, and pN_rvalid is high for exactly the following cycle.
- pN_rdata holds its value until the next read on that port.
- Requests are level-held: an ungranted port keeps req and fields stable until granted.
- A port may issue back-to-back reads. rvalid then stays high on consecutive cycles with new data each cycle.
- Simultaneous requests every cycle: port 0 takes MAX_HOLD grants, then port 1 takes 1 grant. The pattern repeats.
- stall is high exactly in the cycles p0 requests and p1 is granted.
- Reset asserted mid-operation: rvalid clears immediately and any pending read return is discarded. The access in flight is not guaranteed to complete.

Test Plan:
- Reset: hold rst_n=0 with p0_req=p1_req=1 → all grants, strobes, rvalids 0. Release → p0_gnt=1 in the first cycle.
- p0 read only: p0_req=1, p0_we=0, addr 0x10, memory[0x10]=0xDEADBEEF → mem_read=1 the same cycle. Next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF. The cycle after, rvalid=0.
- p1 write while p0 idle: p1 writes 0x12345678 to 0x20 → p1_gnt=1, mem_write=1, stall=0. A later p0 read of 0x20 returns 0x12345678.
- Contention, MAX_HOLD=4, both requesting continuously → grant sequence p0,p0,p0,p0,p1 repeating. stall=1 only on the p1 cycles.
- Routing: p0 read 0x10, then p1 read 0x20 in the next cycle → rvalid/rdata appear only on the matching port, one cycle after each grant.
- Async reset asserted during a p1 read grant → p1_rvalid stays 0, hold_cnt=0 after release.
